bus_master_if: RTL and testbench

CPU-side bus master interface: converts a pipeline stage's single-word memory access into the shared-bus request/grant/access/ready protocol. Sits directly upstream of the bus (arbiter + master mux) as one master channel. Holds the pipeline with a busy stall until the addressed slave signals ready, then returns read data. An optional watchdog aborts accesses to unresponsive slaves.

---
 rtl/bus_master_pkg.sv | 20 ++
 rtl/bus_master_if_if.sv | 31 +++
 rtl/bus_master_timeout.sv | 31 +++
 rtl/bus_master_if.sv | 144 ++++++++++++++
 tb/tb_bus_master_if.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_master_pkg.sv
// rtl/bus_master_pkg.sv - shared encodings for the bus master channel
// Holds the state encoding, default widths, read/write encodings and the
// watchdog default shared with the arbiter and master mux.
package bus_master_pkg;

  localparam int BM_ADDR_W      = 30;
  localparam int BM_DATA_W      = 32;
  localparam int BM_TIMEOUT_CYC = 255;

  localparam logic BM_RW_READ  = 1'b1;
  localparam logic BM_RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACCESS = 2'd2,
    ST_STALL  = 2'd3
  } bm_state_t;

endpackage

// File: rtl/bus_master_if_if.sv
// rtl/bus_master_if_if.sv - shared-bus signal bundle for one master channel
// master modport: bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data out;
//                 bus_grnt_, bus_rd_data, bus_rdy_ in.
// slave modport:  the arbiter/mux side, directions reversed.
interface bus_master_if_if
  import bus_master_pkg::*;
#(
  parameter int ADDR_W = BM_ADDR_W,
  parameter int DATA_W = BM_DATA_W
) ();

  logic              bus_req_;
  logic              bus_grnt_;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_as_;
  logic              bus_rw;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_rdy_;

  modport master (
    output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
    input  bus_grnt_, bus_rd_data, bus_rdy_
  );

  modport slave (
    input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
    output bus_grnt_, bus_rd_data, bus_rdy_
  );

endinterface

// File: rtl/bus_master_timeout.sv
// rtl/bus_master_timeout.sv - access watchdog counter (BUS_MASTER_TIMEOUT_EN builds)
// Ports: clk, reset (async active-low), start (clear on ACCESS entry),
//        tick (ACCESS cycle without ready), expired (count reached TIMEOUT_CYC).
module bus_master_timeout
  import bus_master_pkg::*;
#(
  parameter int TIMEOUT_CYC = BM_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic tick,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 8'd1;
    end
  end

  // The owner leaves ACCESS on the expiring cycle, so cnt never wraps.
  assign expired = (cnt == 8'(TIMEOUT_CYC));

endmodule

// File: rtl/bus_master_if.sv
// rtl/bus_master_if.sv - CPU-side single-word bus master channel
// Ports: clk, reset (async active-low); pipeline side cpu_as_, cpu_rw,
//        cpu_addr, cpu_wr_data, stall, flush in; cpu_rd_data, busy, err out;
//        bus: bus_master_if_if.master bundle toward arbiter and muxes.
// Optional watchdog: define BUS_MASTER_TIMEOUT_EN.
module bus_master_if
  import bus_master_pkg::*;
#(
  parameter int ADDR_W      = BM_ADDR_W,
  parameter int DATA_W      = BM_DATA_W,
  parameter int TIMEOUT_CYC = BM_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_as_,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              busy,
  output logic              err,
  bus_master_if_if.master   bus
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_timeout_range
    $error("TIMEOUT_CYC must be within 1..255");
  end

  bm_state_t         state, state_nxt;
  logic              req_q, as_q, rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rd_buf;
  logic              accept, timeout_hit;

  assign bus.bus_req_    = req_q;
  assign bus.bus_as_     = as_q;
  assign bus.bus_rw      = rw_q;
  assign bus.bus_addr    = addr_q;
  assign bus.bus_wr_data = wdata_q;

`ifdef BUS_MASTER_TIMEOUT_EN
  logic to_expired;

  bus_master_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .start   ((state == ST_REQ) && !flush && !bus.bus_grnt_),
    .tick    ((state == ST_ACCESS) && bus.bus_rdy_),
    .expired (to_expired)
  );

  // A ready arriving on the expiring cycle still wins.
  assign timeout_hit = (state == ST_ACCESS) && bus.bus_rdy_ && to_expired;
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    err         = 1'b0;
    accept      = 1'b0;
    cpu_rd_data = rd_buf;
    case (state)
      ST_IDLE: begin
        if (!cpu_as_ && !flush) begin
          accept    = 1'b1;
          busy      = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        busy = 1'b1;
        if (flush) begin
          state_nxt = ST_IDLE;
        end else if (!bus.bus_grnt_) begin
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!bus.bus_rdy_) begin
          // Read data bypasses rd_buf so the pipeline sees it this cycle.
          if (rw_q == BM_RW_READ) cpu_rd_data = bus.bus_rd_data;
          state_nxt = stall ? ST_STALL : ST_IDLE;
        end else if (timeout_hit) begin
          err         = 1'b1;
          cpu_rd_data = '0;
          state_nxt   = stall ? ST_STALL : ST_IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      ST_STALL: begin
        if (!stall) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      req_q   <= 1'b1;
      as_q    <= 1'b1;
      rw_q    <= BM_RW_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_buf  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q  <= cpu_addr;
            rw_q    <= cpu_rw;
            wdata_q <= cpu_wr_data;
            req_q   <= 1'b0;
          end
        end
        ST_REQ: begin
          if (flush) begin
            req_q <= 1'b1;
          end else if (!bus.bus_grnt_) begin
            as_q <= 1'b0;
          end
        end
        ST_ACCESS: begin
          as_q <= 1'b1;
          if (!bus.bus_rdy_) begin
            req_q <= 1'b1;
            if (rw_q == BM_RW_READ) rd_buf <= bus.bus_rd_data;
          end else if (timeout_hit) begin
            req_q  <= 1'b1;
            rd_buf <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_if.sv
// tb/tb_bus_master_if.sv - scoreboard bench for bus_master_if
`timescale 1ns/1ps
module tb_bus_master_if;
  import bus_master_pkg::*;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int TO = 8;

  typedef struct {
    bit              rw;
    bit              err;
    logic [DW-1:0]   data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_as_ = 1'b1;
  logic          cpu_rw = 1'b1;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wr_data = '0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] cpu_rd_data;
  logic          busy;
  logic          err;

  int            errors = 0;
  int            checks = 0;
  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] exp_rd_buf = '0;

  bus_master_if_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

  bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_as_     (cpu_as_),
    .cpu_rw      (cpu_rw),
    .cpu_addr    (cpu_addr),
    .cpu_wr_data (cpu_wr_data),
    .stall       (stall),
    .flush       (flush),
    .cpu_rd_data (cpu_rd_data),
    .busy        (busy),
    .err         (err),
    .bus         (bif)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: a completion is the only cycle with the request still asserted
  // and busy released.
  always @(negedge clk) begin
    if (reset) begin
      if (bif.bus_req_ == 1'b0 && busy == 1'b0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: completion with empty scoreboard, rd=%0h", cpu_rd_data);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.rw || mon_e.err) check("done_rd_data", cpu_rd_data, mon_e.data);
          check("done_err", err, mon_e.err);
          if (mon_e.err) exp_rd_buf = '0;
          else if (mon_e.rw) exp_rd_buf = mon_e.data;
        end
      end else begin
        check("rd_hold", cpu_rd_data, exp_rd_buf);
        check("err_quiet", err, 0);
      end
    end
  end

  task automatic access(input bit rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [DW-1:0] rd, input int gdly, input int waits,
                        input int stall_cyc, input bit abort);
    int   n;
    int   busy_cnt;
    int   as_cnt;
    exp_t e;
    n        = 3 + gdly + waits;
    e.rw     = rw;
    e.err    = abort;
    e.data   = abort ? '0 : rd;
    sb.push_back(e);
    busy_cnt = 0;
    as_cnt   = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      flush = 1'b0;
      if (i == 0) begin
        cpu_as_ = 1'b0; cpu_rw = rw; cpu_addr = addr; cpu_wr_data = wd;
      end else begin
        cpu_as_ = 1'b1; cpu_rw = 1'($urandom); cpu_addr = AW'($urandom); cpu_wr_data = $urandom;
      end
      bif.bus_grnt_   = (i >= 1 + gdly) ? 1'b0 : 1'b1;
      bif.bus_rdy_    = (i == n - 1 && !abort) ? 1'b0 : 1'b1;
      bif.bus_rd_data = (i == n - 1) ? rd : $urandom;
      stall           = (i == n - 1) && (stall_cyc > 0);
      @(negedge clk);
      if (i == 0) begin
        check("idle_req", bif.bus_req_, 1);
        check("idle_as", bif.bus_as_, 1);
      end else begin
        check("bus_addr", bif.bus_addr, addr);
        check("bus_rw", bif.bus_rw, rw);
        if (!rw) check("bus_wdata", bif.bus_wr_data, wd);
      end
      if (busy) busy_cnt++;
      if (!bif.bus_as_) as_cnt++;
    end
    check("busy_cycles", busy_cnt, n - 1);
    check("as_low_cycles", as_cnt, 1);
    for (int s = 1; s < stall_cyc; s++) begin
      @(posedge clk); #1;
      cpu_as_ = 1'b0; stall = 1'b1;
      bif.bus_grnt_ = 1'b1; bif.bus_rdy_ = 1'b1;
      @(negedge clk);
      check("stall_busy", busy, 0);
      check("stall_req", bif.bus_req_, 1);
    end
    if (stall_cyc > 0) begin
      @(posedge clk); #1;
      stall = 1'b0; bif.bus_grnt_ = 1'b1; bif.bus_rdy_ = 1'b1;
      @(negedge clk);
      check("stall_release_busy", busy, 0);
    end
    @(posedge clk); #1;
    cpu_as_ = 1'b1; bif.bus_grnt_ = 1'b1; bif.bus_rdy_ = 1'b1;
  endtask

  task automatic flush_test();
    @(posedge clk); #1;
    cpu_as_ = 1'b0; cpu_rw = 1'b1; cpu_addr = 30'h55; flush = 1'b0; bif.bus_grnt_ = 1'b1;
    @(negedge clk);
    check("flush_t0_busy", busy, 1);
    @(posedge clk); #1;
    cpu_as_ = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_req_busy", busy, 1);
    check("flush_req_low", bif.bus_req_, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_req_back", bif.bus_req_, 1);
    check("flush_as", bif.bus_as_, 1);
    check("flush_idle_busy", busy, 0);
  endtask

  task automatic reset_mid(input int hold);
    @(posedge clk); #1;
    cpu_as_ = 1'b0; cpu_rw = 1'b1; cpu_addr = 30'h3A5; bif.bus_grnt_ = 1'b1; bif.bus_rdy_ = 1'b1;
    @(posedge clk); #1;
    cpu_as_ = 1'b1; bif.bus_grnt_ = 1'b0;
    @(posedge clk); #1;
    repeat (hold) @(posedge clk);
    #1;
    if (hold == 0) check("as_before_reset", bif.bus_as_, 0);
    else check("hang_busy", busy, 1);
    check("req_before_reset", bif.bus_req_, 0);
    reset = 1'b0;
    exp_rd_buf = '0;
    #1;
    check("rst_req_now", bif.bus_req_, 1);
    check("rst_as_now", bif.bus_as_, 1);
    check("rst_busy_now", busy, 0);
    check("rst_rd_now", cpu_rd_data, 0);
    bif.bus_grnt_ = 1'b1;
    @(posedge clk); #2;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation bound reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    bif.bus_grnt_ = 1'b1;
    bif.bus_rdy_ = 1'b1;
    bif.bus_rd_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bus_req", bif.bus_req_, 1);
    check("rst_bus_as", bif.bus_as_, 1);
    check("rst_bus_rw", bif.bus_rw, 1);
    check("rst_bus_addr", bif.bus_addr, 0);
    check("rst_bus_wdata", bif.bus_wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_rd", cpu_rd_data, 0);
    check("rst_err", err, 0);
    @(posedge clk); #2;
    reset = 1'b1;

    access(1'b1, 30'h0000100, 32'h0, 32'hDEADBEEF, 0, 0, 0, 1'b0);
    access(1'b0, 30'h0000200, 32'h12345678, $urandom, 3, 2, 0, 1'b0);
    flush_test();
    access(1'b1, 30'h0000300, 32'h0, 32'hA5A5A5A5, 0, 0, 4, 1'b0);
    access(1'b1, 30'h0000304, 32'h0, 32'h0BADF00D, 0, 1, 0, 1'b0);
`ifdef BUS_MASTER_TIMEOUT_EN
    access(1'b1, 30'h0000400, 32'h0, $urandom, 0, TO, 0, 1'b1);
    access(1'b1, 30'h0000404, 32'h0, 32'hC0FFEE11, 1, 0, 2, 1'b0);
    access(1'b1, 30'h0000408, 32'h0, $urandom, 2, TO, 0, 1'b1);
`else
    reset_mid(300);
`endif
    reset_mid(0);
    access(1'b1, 30'h0000500, 32'h0, 32'h600DCAFE, 0, 0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      access(1'($urandom_range(0, 1)), AW'($urandom), $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("final_req", bif.bus_req_, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
